hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the five-stage MIPS core, sitting directly downstream of the D-stage instruction decoder. Each cycle it consumes the D-stage instruction word and its 4-bit type class. It tracks type, destination and source registers of the instructions in E, M and W in its own shadow pipeline. From that state it produces the D-stage stall request and the forwarding selects for the D-stage branch comparator and the E-stage ALU. It also keeps a saturating count of stall cycles for performance debug.

## Interface
- `CNT_W`, 16: width of the stall counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous reset, active low.
- `Instr_D`  in  32  instruction currently in D.
- `InstrType_D`  in  4  decoder class of `Instr_D`:
  - 0 = other/nop, 1 = R-type, 2 = immediate ALU, 3 = beq, 4 = load, 5 = jr, 6 = jal, 7 = store.
- `stall`  out  1  freeze PC and the IF/ID register, and insert a bubble into E.
- `fwd_rs_D`  out  1  branch/jr rs operand: 1 = take the M-stage result, 0 = take the register file.
- `fwd_rt_D`  out  1  same as `fwd_rs_D`, for rt.
- `fwd_rs_E`  out  2  ALU rs operand: 2 = M result, 1 = W result, 0 = ID/EX value.
- `fwd_rt_E`  out  2  same as `fwd_rs_E`, for rt.
- `stall_cnt`  out  CNT_W  number of cycles with `stall` = 1, saturating at all-ones.

## Operation
- **D-stage field extraction** (combinational):
  - `rs` = `Instr_D[25:21]`; `rt` = `Instr_D[20:16]`.
  - rs is used by types 1, 2, 3, 4, 5, 7.
  - rt is used by types 1, 3, 7.
  - Destination register:
    - type 1 → `Instr_D[15:11]`
    - types 2 and 4 → rt
    - type 6 → 31
    - all other types → 0
  - An unused source is treated as register 0.
- **Shadow pipeline**: stages E, M and W each hold {type[3:0], dst[4:0], rs[4:0], rt[4:0]}. Every edge:
  - W ← M and M ← E.
  - E ← D fields if `stall` = 0; otherwise E ← bubble (type 0, all fields 0).
- **Writer classes**:
  - E-writer: E type ∈ {1, 2, 4, 6} with dst ≠ 0.
  - M ALU-writer: M type ∈ {1, 2, 6} with dst ≠ 0.
  - M load: M type = 4 with dst ≠ 0.
  - W writer: W type ∈ {1, 2, 4, 6} with dst ≠ 0.
  - Register 0 never matches.
- **`stall` = 1** (combinational) when either condition holds:
  - Load-use: E type = 4, E dst ≠ 0, and E dst equals a used D source (any type).
  - Branch/jr: D type ∈ {3, 5}, and a used D source equals the dst of an E-writer or of an M load.
- **D-stage forwarding**:
  - `fwd_rs_D` = 1 iff D type ∈ {3, 5} and rs matches the M ALU-writer dst.
  - `fwd_rt_D` = 1 iff D type = 3 and rt matches the M ALU-writer dst.
  - Both are 0 while `stall` = 1.
- **E-stage forwarding**: E stores rs/rt already masked by usage. For `fwd_rs_E` / `fwd_rt_E`:
  - 2 if the E source matches the M ALU-writer dst.
  - Otherwise 1 if it matches the W writer dst.
  - Otherwise 0.
  - M has priority over W.
  - A load in M never forwards from M; load-use stalling guarantees it reaches W first.
- **Counter**: `stall_cnt` increments on every edge where `stall` = 1 and it is not already all-ones; otherwise it holds.

## Timing
- **Reset**: on an edge with `rst_n` = 0, all stage entries are cleared to bubble and `stall_cnt` is cleared to 0. With D type 0 the outputs then read `stall` = 0 and every forward select = 0.
  - Reset asserted mid-stall takes priority over increment and shift.
  - `stall` may be high in that same cycle, since it is combinational, but no stall-driven state change occurs.
- **Output paths**:
  - `stall` and `fwd_*_D` are combinational from D inputs plus registered state, with zero latency.
  - `fwd_*_E` and `stall_cnt` depend only on registers.
- **Stall durations**:
  - Load-use: exactly 1 stall cycle.
  - beq/jr directly after an ALU writer: 1 cycle. The second cycle then forwards from M.
  - beq/jr directly after a load: 2 cycles, covering the E and M occupancy.
- **Simultaneous matches**: when the M and W dst values are equal, M wins.
- **Counter saturation**: at all-ones it holds and never wraps to 0.

## Test plan
- **Load-use**: `lw $8,0($9)`, then `addu $10,$8,$11` → `stall` = 1 for one cycle, E bubble. Next cycle `addu` is in E with `fwd_rs_E` = 1 (lw in W); `stall_cnt` = 1.
- **Branch after ALU**: `addu $3,$1,$2`, then `beq $3,$4,x` → one stall cycle, then `fwd_rs_D` = 1 and `fwd_rt_D` = 0.
- **Branch after load**: `lw $5,...`, then `jr $5` → `stall` = 1 for two cycles; no D forward (loaded value is in W / register file); `stall_cnt` = 2.
- **E forwarding priority**: `ori $7,...`, `addu $7,...`, then `subu $2,$7,$7` → `fwd_rs_E` = 2 and `fwd_rt_E` = 2; with one nop inserted instead → both = 1.
- **Register 0 and jal**: `ori $0,...`, then `addu $1,$0,$0` → no stall, forwards 0. `jal`, then `addu $2,$31,$0` → `fwd_rs_E` = 2.
- **Reset and saturation**: with `CNT_W` = 2, hold a load-use pattern for 5 cycles → `stall_cnt` stays at 3. Assert `rst_n` = 0 for one cycle during a stall → `stall_cnt` = 0 and E/M/W are bubbles.

Source files
------------

// File: rtl/hazard_unit.sv
// Hazard controller for the five-stage MIPS core: tracks E/M/W in a shadow
// pipeline and produces the D-stage stall plus D/E forwarding selects.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      Instr_D,
  input  logic [3:0]       InstrType_D,
  output logic             stall,
  output logic             fwd_rs_D,
  output logic             fwd_rt_D,
  output logic [1:0]       fwd_rs_E,
  output logic [1:0]       fwd_rt_E,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [3:0] T_RTYPE = 4'd1;
  localparam logic [3:0] T_IALU  = 4'd2;
  localparam logic [3:0] T_BEQ   = 4'd3;
  localparam logic [3:0] T_LOAD  = 4'd4;
  localparam logic [3:0] T_JR    = 4'd5;
  localparam logic [3:0] T_JAL   = 4'd6;
  localparam logic [3:0] T_STORE = 4'd7;

  typedef struct packed {
    logic [3:0] typ;
    logic [4:0] dst;
    logic [4:0] rs;
    logic [4:0] rt;
  } stage_t;

  localparam stage_t BUBBLE = '0;

  stage_t d_s;
  stage_t e_q, e_d, m_q, m_d, w_q, w_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic e_writer, e_load, m_alu, m_load, w_writer, d_branch;
  logic load_use, branch_haz;

  // Unused sources collapse to $0 so they can never match a writer.
  always_comb begin
    d_s     = BUBBLE;
    d_s.typ = InstrType_D;
    if (InstrType_D inside {T_RTYPE, T_IALU, T_BEQ, T_LOAD, T_JR, T_STORE})
      d_s.rs = Instr_D[25:21];
    if (InstrType_D inside {T_RTYPE, T_BEQ, T_STORE})
      d_s.rt = Instr_D[20:16];
    case (InstrType_D)
      T_RTYPE:        d_s.dst = Instr_D[15:11];
      T_IALU, T_LOAD: d_s.dst = Instr_D[20:16];
      T_JAL:          d_s.dst = 5'd31;
      default:        d_s.dst = 5'd0;
    endcase
  end

  assign e_writer = (e_q.typ inside {T_RTYPE, T_IALU, T_LOAD, T_JAL}) && (e_q.dst != 5'd0);
  assign e_load   = (e_q.typ == T_LOAD) && (e_q.dst != 5'd0);
  assign m_alu    = (m_q.typ inside {T_RTYPE, T_IALU, T_JAL}) && (m_q.dst != 5'd0);
  assign m_load   = (m_q.typ == T_LOAD) && (m_q.dst != 5'd0);
  assign w_writer = (w_q.typ inside {T_RTYPE, T_IALU, T_LOAD, T_JAL}) && (w_q.dst != 5'd0);
  assign d_branch = (d_s.typ == T_BEQ) || (d_s.typ == T_JR);

  always_comb begin
    load_use   = e_load && ((e_q.dst == d_s.rs) || (e_q.dst == d_s.rt));
    branch_haz = d_branch &&
                 ((e_writer && ((e_q.dst == d_s.rs) || (e_q.dst == d_s.rt))) ||
                  (m_load   && ((m_q.dst == d_s.rs) || (m_q.dst == d_s.rt))));
    stall      = load_use || branch_haz;
    fwd_rs_D   = !stall && d_branch && m_alu && (m_q.dst == d_s.rs);
    fwd_rt_D   = !stall && (d_s.typ == T_BEQ) && m_alu && (m_q.dst == d_s.rt);
  end

  // M beats W; a load in M is deliberately excluded from forwarding.
  always_comb begin
    fwd_rs_E = 2'd0;
    fwd_rt_E = 2'd0;
    if (m_alu && (m_q.dst == e_q.rs))         fwd_rs_E = 2'd2;
    else if (w_writer && (w_q.dst == e_q.rs)) fwd_rs_E = 2'd1;
    if (m_alu && (m_q.dst == e_q.rt))         fwd_rt_E = 2'd2;
    else if (w_writer && (w_q.dst == e_q.rt)) fwd_rt_E = 2'd1;
  end

  always_comb begin
    e_d   = stall ? BUBBLE : d_s;
    m_d   = e_q;
    w_d   = m_q;
    cnt_d = cnt_q;
    if (stall && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_q   <= BUBBLE;
      m_q   <= BUBBLE;
      w_q   <= BUBBLE;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: a default-width instance plus a 2-bit
// counter instance on the same inputs for the saturation case.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic [3:0]  itype;

  logic        stall, fwd_rs_D, fwd_rt_D;
  logic [1:0]  fwd_rs_E, fwd_rt_E;
  logic [15:0] stall_cnt;

  logic        s_stall, s_fwd_rs_D, s_fwd_rt_D;
  logic [1:0]  s_fwd_rs_E, s_fwd_rt_E;
  logic [1:0]  s_stall_cnt;

  int checks   = 0;
  int failures = 0;

  localparam logic [3:0] NOP = 4'd0, RT = 4'd1, IALU = 4'd2, BEQ = 4'd3,
                         LW = 4'd4, JR = 4'd5, JAL = 4'd6;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk(clk), .rst_n(rst_n), .Instr_D(instr), .InstrType_D(itype),
    .stall(stall), .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
    .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E), .stall_cnt(stall_cnt)
  );

  hazard_unit #(.CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .Instr_D(instr), .InstrType_D(itype),
    .stall(s_stall), .fwd_rs_D(s_fwd_rs_D), .fwd_rt_D(s_fwd_rt_D),
    .fwd_rs_E(s_fwd_rs_E), .fwd_rt_E(s_fwd_rt_E), .stall_cnt(s_stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Field layout only matters for rs/rt/rd; opcode/funct bits are irrelevant here.
  task automatic drv(input logic [3:0] t, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd);
    itype = t;
    instr = {6'd0, rs, rt, rd, 11'd0};
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    drv(NOP, 5'd0, 5'd0, 5'd0);
    repeat (3) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    drv(NOP, 5'd0, 5'd0, 5'd0);
    tick();
    tick();
    chk("rst_stall", stall, 0);
    chk("rst_fwd_rs_D", fwd_rs_D, 0);
    chk("rst_fwd_rt_D", fwd_rt_D, 0);
    chk("rst_fwd_rs_E", fwd_rs_E, 0);
    chk("rst_fwd_rt_E", fwd_rt_E, 0);
    chk("rst_cnt", stall_cnt, 0);
    rst_n = 1'b1;

    // reset asserted during a load-use stall
    drv(LW, 5'd9, 5'd8, 5'd0);
    tick();
    drv(RT, 5'd8, 5'd11, 5'd10);
    rst_n = 1'b0;
    #1;
    chk("rstmid_stall_comb", stall, 1);
    tick();
    rst_n = 1'b1;
    chk("rstmid_cnt", stall_cnt, 0);
    chk("rstmid_cnt_small", s_stall_cnt, 0);
    chk("rstmid_no_stall", stall, 0);
    tick();
    chk("rstmid_w_bubble", fwd_rs_E, 0);
    flush();

    // load-use
    drv(LW, 5'd9, 5'd8, 5'd0);
    chk("lu_lw_nostall", stall, 0);
    tick();
    drv(RT, 5'd8, 5'd11, 5'd10);
    chk("lu_stall", stall, 1);
    tick();
    chk("lu_release", stall, 0);
    chk("lu_bubble_fwd", fwd_rs_E, 0);
    chk("lu_cnt", stall_cnt, 1);
    chk("lu_cnt_small", s_stall_cnt, 1);
    tick();
    drv(NOP, 5'd0, 5'd0, 5'd0);
    chk("lu_fwd_rs_E_W", fwd_rs_E, 1);
    chk("lu_fwd_rt_E", fwd_rt_E, 0);
    flush();

    // branch after ALU writer
    drv(RT, 5'd1, 5'd2, 5'd3);
    tick();
    drv(BEQ, 5'd3, 5'd4, 5'd0);
    chk("ba_stall", stall, 1);
    chk("ba_fwd_rs_D_masked", fwd_rs_D, 0);
    tick();
    chk("ba_stall2", stall, 0);
    chk("ba_fwd_rs_D", fwd_rs_D, 1);
    chk("ba_fwd_rt_D", fwd_rt_D, 0);
    tick();
    drv(NOP, 5'd0, 5'd0, 5'd0);
    chk("ba_beq_E_fwd_rs", fwd_rs_E, 1);
    chk("ba_cnt", stall_cnt, 2);
    flush();

    // branch (jr) after load
    drv(LW, 5'd6, 5'd5, 5'd0);
    tick();
    drv(JR, 5'd5, 5'd9, 5'd0);
    chk("bl_stall1", stall, 1);
    tick();
    chk("bl_stall2", stall, 1);
    chk("bl_fwd_rs_D_1", fwd_rs_D, 0);
    tick();
    chk("bl_stall3", stall, 0);
    chk("bl_fwd_rs_D_2", fwd_rs_D, 0);
    chk("bl_cnt", stall_cnt, 4);
    chk("bl_cnt_small_sat", s_stall_cnt, 3);
    flush();

    // E forwarding priority M over W
    drv(IALU, 5'd0, 5'd7, 5'd0);
    tick();
    drv(RT, 5'd1, 5'd2, 5'd7);
    tick();
    drv(RT, 5'd7, 5'd7, 5'd2);
    chk("pri_no_stall", stall, 0);
    tick();
    drv(NOP, 5'd0, 5'd0, 5'd0);
    chk("pri_fwd_rs_E", fwd_rs_E, 2);
    chk("pri_fwd_rt_E", fwd_rt_E, 2);
    flush();
    drv(IALU, 5'd0, 5'd7, 5'd0);
    tick();
    drv(NOP, 5'd0, 5'd0, 5'd0);
    tick();
    drv(RT, 5'd7, 5'd7, 5'd2);
    tick();
    drv(NOP, 5'd0, 5'd0, 5'd0);
    chk("w_fwd_rs_E", fwd_rs_E, 1);
    chk("w_fwd_rt_E", fwd_rt_E, 1);
    flush();

    // register 0 never matches
    drv(IALU, 5'd0, 5'd0, 5'd0);
    tick();
    drv(RT, 5'd0, 5'd0, 5'd1);
    chk("r0_no_stall", stall, 0);
    tick();
    drv(NOP, 5'd0, 5'd0, 5'd0);
    chk("r0_fwd_rs_E", fwd_rs_E, 0);
    chk("r0_fwd_rt_E", fwd_rt_E, 0);
    flush();

    // jal writes $31
    drv(JAL, 5'd3, 5'd4, 5'd5);
    tick();
    drv(RT, 5'd31, 5'd0, 5'd2);
    chk("jal_no_stall", stall, 0);
    tick();
    drv(NOP, 5'd0, 5'd0, 5'd0);
    chk("jal_fwd_rs_E", fwd_rs_E, 2);
    chk("jal_fwd_rt_E", fwd_rt_E, 0);
    flush();

    // five load-use stalls: 2-bit counter pins at 3
    drv(LW, 5'd9, 5'd8, 5'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drv(LW, 5'd8, 5'd8, 5'd0);
      chk("sat_stall", stall, 1);
      tick();
      tick();
    end
    chk("sat_cnt_small", s_stall_cnt, 3);
    chk("sat_cnt", stall_cnt, 9);
    flush();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
